pdu_hex_input: RTL and testbench
================================

PDU_HEX_INPUT -- requirements
Module: pdu_hex_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the consecutive stable cycles a button needs before its debounced level changes (10 ms at 100 MHz).
REQ-002 SHALL have port clk, input, 1, system clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sw_hex, input, 4, hex digit value from the switches, sampled when a push is accepted.
REQ-005 SHALL have port btn_push, input, 1, raw asynchronous bouncing button that appends a digit.
REQ-006 SHALL have port btn_del, input, 1, raw asynchronous bouncing button that deletes the last digit.
REQ-007 SHALL have port btn_ok, input, 1, raw asynchronous bouncing button that commits the buffer.
REQ-008 SHALL have port data_out, output, 32, working buffer that feeds the 8-digit segment scanner; digit 0 is bits [3:0].
REQ-009 SHALL have port digit_cnt, output, 4, number of digits entered (0..8).
REQ-010 SHALL have port full, output, 1, high when digit_cnt equals 8.
REQ-011 SHALL have port commit_valid, output, 1, high when commit_data is offered to the consumer.
REQ-012 SHALL have port commit_data, output, 32, committed value.
REQ-013 SHALL have port commit_ready, input, 1, consumer accept signal.

Function
REQ-014 Each raw button SHALL pass through a 2-flop synchronizer and then an independent debouncer.
REQ-015 Debouncer: the debounced level SHALL flip only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap resets the counter to 0.
REQ-016 A rising edge of a debounced level SHALL produce a single-cycle event pulse; falling edges produce no event.
REQ-017 Latency from a raw rising edge, held stable, to the data_out/digit_cnt update SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-018 State machine SHALL have two states, EDIT and COMMIT; reset enters EDIT.
REQ-019 In EDIT, a push event with digit_cnt<8 SHALL set data_out to {data_out[27:0], sw_hex} and increment digit_cnt.
REQ-020 In EDIT, a push event with digit_cnt==8 SHALL be ignored; data_out and digit_cnt remain unchanged.
REQ-021 In EDIT, a delete event with digit_cnt>0 SHALL set data_out to {4'h0, data_out[31:4]} and decrement digit_cnt; with digit_cnt==0 it SHALL be ignored.
REQ-022 In EDIT, an ok event SHALL load commit_data with data_out, assert commit_valid on the next cycle, and enter COMMIT; this applies for any digit_cnt, including 0.
REQ-023 When events coincide in the same cycle, priority SHALL be ok > delete > push; lower-priority events are dropped.
REQ-024 In COMMIT, commit_valid SHALL stay high and commit_data SHALL stay stable until a cycle in which commit_ready is sampled high.
REQ-025 On that handshake cycle, the next edge SHALL deassert commit_valid, clear data_out and digit_cnt to 0, and return to EDIT.
REQ-026 In COMMIT, push, delete and ok events SHALL be discarded, not queued.
REQ-027 commit_ready while in EDIT SHALL have no effect.
REQ-028 full SHALL be combinational from digit_cnt.

Reset
REQ-029 On rst, data_out, digit_cnt, commit_data and commit_valid SHALL be 0, and the state SHALL be EDIT.
REQ-030 On rst, synchronizers, debounced levels, debounce counters and event pulses SHALL be cleared to 0.
REQ-031 Reset SHALL take effect on the next edge regardless of state, including mid-COMMIT and mid-debounce.
REQ-032 A button held through reset release SHALL re-debounce from count 0 and then generate one event.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Clean press with sw_hex=A, held 10 cycles: data_out=0000000A and digit_cnt=1 exactly 7 cycles after the raw rise; there is exactly one event.
REQ-034 Bounce: btn_push toggles every 2 cycles for 12 cycles, then stays high: exactly one push event is generated.
REQ-035 Eight pushes of 1..8 followed by a push of F: data_out=12345678, full=1, and the ninth push is ignored; then a delete gives 01234567 with digit_cnt=7.
REQ-036 Delete with digit_cnt=0: no change. ok and push debounced in the same cycle: commit taken and the push dropped.
REQ-037 Commit of 0000BEEF with commit_ready held low for 20 cycles: commit_valid=1 and the data stays stable while presses are ignored; commit_ready pulse then gives data_out=0, digit_cnt=0, commit_valid=0 on the next cycle.
REQ-038 rst asserted during COMMIT: all outputs are 0 on the next cycle, and a subsequent press works normally.

Source files
------------

// File: rtl/pdu_hex_input.sv
// Hex keypad entry: three debounced buttons build an 8-digit value that is
// offered downstream through a valid/ready commit handshake.
module pdu_hex_input #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw_hex,
    input  logic        btn_push,
    input  logic        btn_del,
    input  logic        btn_ok,
    output logic [31:0] data_out,
    output logic [3:0]  digit_cnt,
    output logic        full,
    output logic        commit_valid,
    output logic [31:0] commit_data,
    input  logic        commit_ready
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int BTN_PUSH = 0;
    localparam int BTN_DEL  = 1;
    localparam int BTN_OK   = 2;

    typedef enum logic {EDIT, COMMIT} state_t;

    logic [2:0] btn_raw;
    logic [2:0] btn_event;

    assign btn_raw = {btn_ok, btn_del, btn_push};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          event_reg;
            logic [CW-1:0] cnt_reg;

            // The event is registered alongside the level flip so the FSM
            // acts on the edge right after the debounced level rises.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    event_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    event_reg <= 1'b0;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            level_reg <= sync2_reg;
                            event_reg <= sync2_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign btn_event[gi] = event_reg;
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [31:0] data_reg, data_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] commit_data_reg, commit_data_next;
    logic        commit_valid_reg, commit_valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= EDIT;
            data_reg         <= '0;
            cnt_reg          <= '0;
            commit_data_reg  <= '0;
            commit_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            data_reg         <= data_next;
            cnt_reg          <= cnt_next;
            commit_data_reg  <= commit_data_next;
            commit_valid_reg <= commit_valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        data_next         = data_reg;
        cnt_next          = cnt_reg;
        commit_data_next  = commit_data_reg;
        commit_valid_next = commit_valid_reg;
        case (state_reg)
            EDIT: begin
                // ok outranks delete, which outranks push
                if (btn_event[BTN_OK]) begin
                    commit_data_next  = data_reg;
                    commit_valid_next = 1'b1;
                    state_next        = COMMIT;
                end else if (btn_event[BTN_DEL]) begin
                    if (cnt_reg != 4'd0) begin
                        data_next = {4'h0, data_reg[31:4]};
                        cnt_next  = cnt_reg - 4'd1;
                    end
                end else if (btn_event[BTN_PUSH]) begin
                    if (cnt_reg != 4'd8) begin
                        data_next = {data_reg[27:0], sw_hex};
                        cnt_next  = cnt_reg + 4'd1;
                    end
                end
            end
            COMMIT: begin
                if (commit_ready) begin
                    commit_valid_next = 1'b0;
                    data_next         = '0;
                    cnt_next          = '0;
                    state_next        = EDIT;
                end
            end
            default: state_next = EDIT;
        endcase
    end

    assign data_out     = data_reg;
    assign digit_cnt    = cnt_reg;
    assign full         = (cnt_reg == 4'd8);
    assign commit_valid = commit_valid_reg;
    assign commit_data  = commit_data_reg;

endmodule

// File: tb/tb_pdu_hex_input.sv
// Directed bench for pdu_hex_input with a short debounce window.
module tb_pdu_hex_input;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_hex;
    logic        btn_push, btn_del, btn_ok;
    logic [31:0] data_out;
    logic [3:0]  digit_cnt;
    logic        full;
    logic        commit_valid;
    logic [31:0] commit_data;
    logic        commit_ready;

    int checks = 0;
    int passed = 0;

    pdu_hex_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_hex       (sw_hex),
        .btn_push     (btn_push),
        .btn_del      (btn_del),
        .btn_ok       (btn_ok),
        .data_out     (data_out),
        .digit_cnt    (digit_cnt),
        .full         (full),
        .commit_valid (commit_valid),
        .commit_data  (commit_data),
        .commit_ready (commit_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;       // 0 push, 1 delete, 2 ok
        logic [3:0]  hex;
        logic [31:0] exp_data;
        logic [3:0]  exp_cnt;
        logic        exp_full;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: actual %h required %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int op, input logic [3:0] hex);
        sw_hex = hex;
        case (op)
            0: btn_push = 1'b1;
            1: btn_del  = 1'b1;
            default: btn_ok = 1'b1;
        endcase
        cycles(10);
        btn_push = 1'b0;
        btn_del  = 1'b0;
        btn_ok   = 1'b0;
        cycles(10);
    endtask

    task automatic pulse_ready();
        commit_ready = 1'b1;
        cycles(1);
        commit_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_hex = 4'h0; btn_push = 1'b0; btn_del = 1'b0;
        btn_ok = 1'b0; commit_ready = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        check("reset_data", data_out, 32'h0);
        check("reset_cnt", 32'(digit_cnt), 32'd0);
        check("reset_valid", 32'(commit_valid), 32'd0);
        check("reset_commit_data", commit_data, 32'h0);

        // Latency: update lands exactly 7 edges after the raw rise.
        sw_hex = 4'hA;
        btn_push = 1'b1;
        cycles(6);
        check("latency_early_cnt", 32'(digit_cnt), 32'd0);
        cycles(1);
        check("latency_data", data_out, 32'h0000000A);
        check("latency_cnt", 32'(digit_cnt), 32'd1);
        cycles(3);
        btn_push = 1'b0;
        cycles(12);
        check("single_event_cnt", 32'(digit_cnt), 32'd1);

        // Bounce: 2-cycle toggles never reach the window; final hold gives one event.
        sw_hex = 4'h5;
        for (int i = 0; i < 6; i++) begin
            btn_push = ~btn_push;
            cycles(2);
        end
        btn_push = 1'b1;
        cycles(12);
        btn_push = 1'b0;
        cycles(12);
        check("bounce_cnt", 32'(digit_cnt), 32'd2);
        check("bounce_data", data_out, 32'h000000A5);

        // commit_ready in EDIT does nothing.
        commit_ready = 1'b1;
        cycles(3);
        commit_ready = 1'b0;
        check("ready_in_edit_cnt", 32'(digit_cnt), 32'd2);
        check("ready_in_edit_valid", 32'(commit_valid), 32'd0);

        rst = 1'b1; cycles(1); rst = 1'b0;
        check("rst_clear_data", data_out, 32'h0);

        vecs[0]  = '{1, 4'h0, 32'h00000000, 4'd0, 1'b0};
        vecs[1]  = '{0, 4'h1, 32'h00000001, 4'd1, 1'b0};
        vecs[2]  = '{0, 4'h2, 32'h00000012, 4'd2, 1'b0};
        vecs[3]  = '{0, 4'h3, 32'h00000123, 4'd3, 1'b0};
        vecs[4]  = '{0, 4'h4, 32'h00001234, 4'd4, 1'b0};
        vecs[5]  = '{0, 4'h5, 32'h00012345, 4'd5, 1'b0};
        vecs[6]  = '{0, 4'h6, 32'h00123456, 4'd6, 1'b0};
        vecs[7]  = '{0, 4'h7, 32'h01234567, 4'd7, 1'b0};
        vecs[8]  = '{0, 4'h8, 32'h12345678, 4'd8, 1'b1};
        vecs[9]  = '{0, 4'hF, 32'h12345678, 4'd8, 1'b1};
        vecs[10] = '{1, 4'h0, 32'h01234567, 4'd7, 1'b0};
        for (int i = 0; i < 11; i++) begin
            press(vecs[i].op, vecs[i].hex);
            $display("vec %0d op=%0d hex=%h data_out=%h digit_cnt=%0d full=%0d",
                     i, vecs[i].op, vecs[i].hex, data_out, digit_cnt, full);
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_cnt", i), 32'(digit_cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
        end

        // ok and push debounced together: commit wins, push dropped.
        sw_hex = 4'h9;
        btn_ok = 1'b1; btn_push = 1'b1;
        cycles(10);
        btn_ok = 1'b0; btn_push = 1'b0;
        cycles(10);
        check("coinc_valid", 32'(commit_valid), 32'd1);
        check("coinc_commit_data", commit_data, 32'h01234567);
        check("coinc_data", data_out, 32'h01234567);
        check("coinc_cnt", 32'(digit_cnt), 32'd7);
        pulse_ready();
        check("coinc_hs_valid", 32'(commit_valid), 32'd0);
        check("coinc_hs_data", data_out, 32'h0);
        check("coinc_hs_cnt", 32'(digit_cnt), 32'd0);

        // Commit 0000BEEF, stall the consumer while presses are ignored.
        press(0, 4'hB); press(0, 4'hE); press(0, 4'hE); press(0, 4'hF);
        press(2, 4'h0);
        check("beef_valid", 32'(commit_valid), 32'd1);
        check("beef_commit_data", commit_data, 32'h0000BEEF);
        press(0, 4'h3);
        press(1, 4'h0);
        press(2, 4'h0);
        check("beef_stall_valid", 32'(commit_valid), 32'd1);
        check("beef_stall_cdata", commit_data, 32'h0000BEEF);
        check("beef_stall_data", data_out, 32'h0000BEEF);
        check("beef_stall_cnt", 32'(digit_cnt), 32'd4);
        pulse_ready();
        check("beef_hs_valid", 32'(commit_valid), 32'd0);
        check("beef_hs_data", data_out, 32'h0);
        check("beef_hs_cnt", 32'(digit_cnt), 32'd0);
        cycles(3);
        check("beef_edit_again_valid", 32'(commit_valid), 32'd0);

        // Reset mid-COMMIT with a push held through reset release.
        press(0, 4'h7);
        press(2, 4'h0);
        check("rc_valid", 32'(commit_valid), 32'd1);
        sw_hex = 4'h3;
        btn_push = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        check("rc_data", data_out, 32'h0);
        check("rc_cnt", 32'(digit_cnt), 32'd0);
        check("rc_valid_clr", 32'(commit_valid), 32'd0);
        check("rc_cdata_clr", commit_data, 32'h0);
        rst = 1'b0;
        cycles(12);
        btn_push = 1'b0;
        cycles(12);
        check("rc_held_data", data_out, 32'h00000003);
        check("rc_held_cnt", 32'(digit_cnt), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
